// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU timing generator: sequencer state codes,
// cycle length and the ring next-state function.
package cpu_clk_pkg;

  // Number of master-clock cycles in one instruction cycle.
  localparam int unsigned CYCLE_LEN = 8;

  // State codes double as the phase number (IDLE=0, S1..S8=1..8).
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    S4   = 4'd4,
    S5   = 4'd5,
    S6   = 4'd6,
    S7   = 4'd7,
    S8   = 4'd8
  } state_e;

  // Ring successor: IDLE enters the ring at S1, S8 wraps back to S1, and any
  // code beyond the ring is illegal and recovers through IDLE.
  function automatic state_e next_state(input state_e s);
    logic [3:0] code;
    code = s;
    if (code == 4'(CYCLE_LEN)) begin
      return S1;
    end
    if (code > 4'(CYCLE_LEN)) begin
      return IDLE;
    end
    return state_e'(code + 4'd1);
  endfunction

endpackage

// File: rtl/cpu_clk_gen.sv
// Timing generator for the multi-cycle CPU. An 8-state ring sequencer derives
// the clk/2, clk/4, clk/8 (fetch) phase signals and a one-cycle ALU strobe
// from the master clock; clk1 is the combinational inverse of clk.
// Optional: define CLK_GEN_PHASE_OUT_EN to expose the state code on `phase`.
module cpu_clk_gen
  import cpu_clk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       clk1,
  output logic       clk2,
  output logic       clk4,
  output logic       fetch,
`ifdef CLK_GEN_PHASE_OUT_EN
  output logic [3:0] phase,
`endif
  output logic       alu_clk
);

  state_e state_q;

  // Inverted master clock, valid at all times including reset.
  assign clk1 = ~clk;

`ifdef CLK_GEN_PHASE_OUT_EN
  assign phase = state_q;
`endif

  // Sequencer and registered phase outputs; each state toggles the outputs
  // that change on the edge leaving it. Illegal codes hold outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clk2    <= 1'b0;
      clk4    <= 1'b1;
      fetch   <= 1'b0;
      alu_clk <= 1'b0;
    end else begin
      state_q <= next_state(state_q);
      case (state_q)
        S1: begin
          clk2    <= ~clk2;
          alu_clk <= ~alu_clk;
        end
        S2: begin
          clk2    <= ~clk2;
          clk4    <= ~clk4;
          alu_clk <= ~alu_clk;
        end
        S3: clk2 <= ~clk2;
        S4: begin
          clk2  <= ~clk2;
          clk4  <= ~clk4;
          fetch <= ~fetch;
        end
        S5: clk2 <= ~clk2;
        S6: begin
          clk2 <= ~clk2;
          clk4 <= ~clk4;
        end
        S7: clk2 <= ~clk2;
        S8: begin
          clk2  <= ~clk2;
          clk4  <= ~clk4;
          fetch <= ~fetch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Scoreboard bench for cpu_clk_gen: the driver pushes hand-computed expected
// outputs after each edge, a negedge monitor pops and compares them.
module tb_cpu_clk_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk1, clk2, clk4, fetch, alu_clk;
`ifdef CLK_GEN_PHASE_OUT_EN
  logic [3:0] phase;
`endif

  cpu_clk_gen dut (
    .clk     (clk),
    .reset   (reset),
    .clk1    (clk1),
    .clk2    (clk2),
    .clk4    (clk4),
    .fetch   (fetch),
`ifdef CLK_GEN_PHASE_OUT_EN
    .phase   (phase),
`endif
    .alu_clk (alu_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sig;   // {clk2, clk4, fetch, alu_clk}
    logic [3:0] ph;
    int         tag;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;

  // Outputs after release edge k are steady_tbl[(k+6)%8], hand-derived:
  // k=2:1101 k=3:0000 k=4:1000 k=5:0110 k=6:1110 k=7:0010 k=8:1010 k=9/k=1:0100
  logic [3:0] steady_tbl [8] = '{4'b1101, 4'b0000, 4'b1000, 4'b0110,
                                 4'b1110, 4'b0010, 4'b1010, 4'b0100};
  localparam logic [3:0] ResetSig = 4'b0100;

  task automatic check(input string name, input int tag, input logic [7:0] act,
                       input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, tag, act, req);
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] sig, input logic [3:0] ph,
                      input string name);
    exp_t e;
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    e.sig  = sig;
    e.ph   = ph;
    e.tag  = tag_cnt;
    e.name = name;
    tag_cnt++;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, ResetSig, 4'd0, "reset");
  endtask

  task automatic run(input int n, input string name);
    for (int k = 1; k <= n; k++) begin
      step(1'b0, steady_tbl[(k + 6) % 8], 4'(((k - 1) % 8) + 1), name);
    end
  endtask

  // Monitor: compare registered outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, " clk2/clk4/fetch/alu"}, e.tag,
            {4'b0, clk2, clk4, fetch, alu_clk}, {4'b0, e.sig});
`ifdef CLK_GEN_PHASE_OUT_EN
      check({e.name, " phase"}, e.tag, {4'b0, phase}, {4'b0, e.ph});
`endif
      check({e.name, " clk1 low-phase"}, e.tag, {7'b0, clk1}, 8'd1);
      if (alu_clk === 1'b1) begin
        check({e.name, " strobe fetch/clk4"}, e.tag, {6'b0, fetch, clk4}, 8'd1);
      end
    end
  end

  // clk1 must be low just after every rising edge.
  always @(posedge clk) begin
    #1;
    check("clk1 high-phase", tag_cnt, {7'b0, clk1}, 8'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(3);
    run(72, "startup/steady");
    do_reset(1);
    run(5, "to S5");
    do_reset(1);              // reset while fetch=1
    run(12, "restart");
    do_reset(1);
    run(2, "to strobe");      // alu_clk high here
    do_reset(2);              // reset during strobe
    run(10, "after strobe reset");
    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 0, 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
